btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter NUM_BTN, default 5: number of independent button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: stable-sample count required to accept a level change (10 ms at 100 MHz); legal range 2 to 2^24.
REQ-003 clk  input  1: single system clock; all state updates on rising edge.
REQ-004 rst  input  1: reset; synchronous and active-high.
REQ-005 btn_i  input  NUM_BTN: raw asynchronous push-button levels, 1 = pressed.
REQ-006 btn_level_o  output  NUM_BTN: debounced level per button.
REQ-007 btn_press_o  output  NUM_BTN: one-clk pulse per accepted press.
REQ-008 btn_release_o  output  NUM_BTN: one-clk pulse per accepted release.
REQ-009 any_press_o  output  1: OR of btn_press_o, same cycle.

Function
REQ-010 Each btn_i bit shall pass through a two-flop synchronizer; only the second flop (sync) feeds the channel FSM.
REQ-011 Each channel shall run an independent FSM: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus a counter of width clog2(DEBOUNCE_CYCLES).
REQ-012 IDLE: sync=1 -> PRESS_WAIT with counter cleared to 0; else stay.
REQ-013 PRESS_WAIT: sync=0 -> IDLE (glitch rejected, no pulse); sync=1 and counter<DEBOUNCE_CYCLES-1 -> counter+1; sync=1 and counter=DEBOUNCE_CYCLES-1 -> PRESSED.
REQ-014 PRESSED: sync=0 -> RELEASE_WAIT with counter cleared; else stay.
REQ-015 RELEASE_WAIT: sync=1 -> PRESSED (bounce rejected, no pulse); sync=0 and counter<DEBOUNCE_CYCLES-1 -> counter+1; sync=0 and counter=DEBOUNCE_CYCLES-1 -> IDLE.
REQ-016 btn_level_o shall be 1 in states PRESSED and RELEASE_WAIT, 0 otherwise; registered.
REQ-017 btn_press_o shall be 1 for exactly the one cycle after the PRESS_WAIT->PRESSED edge; btn_release_o likewise for RELEASE_WAIT->IDLE.
REQ-018 Latency: raw input held stable from sampling edge k shall produce press/release pulse and level change after edge k+DEBOUNCE_CYCLES+2.
REQ-019 Counter shall never wrap; it saturates only via the state transition in REQ-013/015.
REQ-020 Channels shall be fully independent; simultaneous presses on several buttons shall yield simultaneous pulses on each.
REQ-021 Press and release pulses on one channel shall never be asserted in the same cycle, and a release pulse shall never occur without a preceding press pulse since reset.
REQ-022 Outputs are in the clk domain; consumers on slower derived clocks shall use btn_level_o, not pulses.

Reset
REQ-023 While rst=1 at a clock edge: synchronizer flops 0, all FSMs IDLE, counters 0, all outputs 0.
REQ-024 Reset asserted mid-debounce or while PRESSED shall discard state with no release pulse; a button held through reset deassertion shall be re-accepted after DEBOUNCE_CYCLES+2 cycles with a press pulse.

Structure
REQ-025 Shared package btn_pkg shall hold the FSM state enum and the default NUM_BTN constant.
REQ-026 One sub-module debounce_ch (synchronizer + FSM + counter for one bit) shall be instanced NUM_BTN times by a generate loop; any_press_o is formed in the top.

Verification (DEBOUNCE_CYCLES=4, NUM_BTN=5)
REQ-027 Reset: rst=1 for 2 cycles with btn_i=5'b11111 -> all outputs 0 during reset; press pulses on all 5 bits 6 cycles after rst falls.
REQ-028 Clean press: btn_i[0] 0->1 held 20 cycles -> btn_press_o[0] single pulse after edge k+6, btn_level_o[0]=1 thereafter, other bits 0.
REQ-029 Glitch: btn_i[2] high for 3 cycles then low -> no pulses, btn_level_o[2] stays 0.
REQ-030 Release bounce: pressed button toggles low 2 cycles, high 1, low 10 -> exactly one btn_release_o pulse, none during bounce, level falls with pulse.
REQ-031 Simultaneous: btn_i=5'b10101 same cycle -> btn_press_o=5'b10101 in one cycle, any_press_o=1 that cycle only.
REQ-032 Mid-operation reset: rst pulsed while btn_i[1] PRESSED, input held -> no release pulse, new press pulse 6 cycles after rst falls.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared debounce FSM states and default channel count
package btn_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  localparam int NUM_BTN_DEF = 5;
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one-button synchronizer, debounce FSM and stability counter
module debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic meta, sync;
  logic [CW-1:0] cnt;
  state_t state;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      meta  <= btn;
      sync  <= meta;
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        IDLE:
          if (sync) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        PRESS_WAIT:
          if (!sync) state <= IDLE;
          else if (cnt == LAST) begin
            state <= PRESSED;
            level <= 1'b1;
            press <= 1'b1;
          end else cnt <= cnt + CW'(1);
        PRESSED:
          if (!sync) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        RELEASE_WAIT:
          if (sync) state <= PRESSED;
          else if (cnt == LAST) begin
            state <= IDLE;
            level <= 1'b0;
            rel   <= 1'b1;
          end else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: NUM_BTN independent debounced buttons with press/release pulses
module btn_debounce
  import btn_pkg::*;
#(
  parameter int NUM_BTN = NUM_BTN_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_press_o,
  output logic [NUM_BTN-1:0] btn_release_o,
  output logic               any_press_o
);
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_i[i]),
      .level(btn_level_o[i]),
      .press(btn_press_o[i]),
      .rel  (btn_release_o[i])
    );
  end
  assign any_press_o = |btn_press_o;
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: randomized and directed checks against a sliding-window reference model
module tb_btn_debounce;
  localparam int N = 5;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] btn;
  logic [N-1:0] level, press, rel;
  logic any;
  int vectors = 0;
  int miscompares = 0;
  logic [N-1:0] m_lvl, m_prs, m_rel;
  logic [N-1:0] hist[$];

  btn_debounce #(.NUM_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_i        (btn),
    .btn_level_o  (level),
    .btn_press_o  (press),
    .btn_release_o(rel),
    .any_press_o  (any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // A level flips once the input seen two edges back has held the opposite value
  // for D+1 consecutive samples; reset discards every sample seen so far.
  task automatic model_edge(input logic r, input logic [N-1:0] b);
    m_prs = '0;
    m_rel = '0;
    if (r) begin
      m_lvl = '0;
      hist = {};
      repeat (D + 3) hist.push_front('0);
    end else begin
      for (int c = 0; c < N; c++) begin
        bit stable = 1'b1;
        for (int j = 1; j <= D + 1; j++)
          if (hist[j][c] == m_lvl[c]) stable = 1'b0;
        if (stable) begin
          if (m_lvl[c]) m_rel[c] = 1'b1;
          else m_prs[c] = 1'b1;
          m_lvl[c] = ~m_lvl[c];
        end
      end
      hist.push_front(b);
      while (hist.size() > D + 3) void'(hist.pop_back());
    end
  endtask

  task automatic cyc(input string tag, input logic r, input logic [N-1:0] b);
    rst = r;
    btn = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    check(tag, 32'({level, press, rel, any}), 32'({m_lvl, m_prs, m_rel, |m_prs}));
  endtask

  task automatic hold(input string tag, input int n, input logic [N-1:0] b);
    repeat (n) cyc(tag, 1'b0, b);
  endtask

  initial begin
    logic [N-1:0] cur;
    rst = 1'b1;
    btn = '0;
    cyc("reset", 1'b1, 5'b11111);
    cyc("reset", 1'b1, 5'b11111);
    hold("reset_hold", 12, 5'b11111);
    hold("all_release", 12, 5'b00000);
    hold("clean_press", 20, 5'b00001);
    hold("clean_release", 10, 5'b00000);
    hold("glitch", 3, 5'b00100);
    hold("glitch_low", 10, 5'b00000);
    hold("bounce_press", 12, 5'b01000);
    hold("bounce_low", 2, 5'b00000);
    hold("bounce_high", 1, 5'b01000);
    hold("bounce_final", 10, 5'b00000);
    hold("simultaneous", 12, 5'b10101);
    hold("simul_release", 10, 5'b00000);
    hold("mid_press", 12, 5'b00010);
    cyc("mid_reset", 1'b1, 5'b00010);
    hold("mid_reaccept", 12, 5'b00010);
    hold("mid_release", 10, 5'b00000);
    cur = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
      cyc("random", $urandom_range(0, 199) == 0, cur);
    end
    hold("drain", 12, 5'b00000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
